muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 143 ++++++++++++++
 tb/tb_muldiv_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Sequential RV32M multiply/divide unit: one bit per cycle, fixed latency for every op.
// The start edge is N and DONE is the cycle after edge N+33. The last CALC step applies the sign.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [4:0]  rd_addr,
  output logic        busy,
  output logic        done,
  output logic        wr_ena,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [2:0]  op_q;
  logic [4:0]  rd_q;
  logic        neg_q;
  logic        div0_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] mcand_q;

  logic        sgn_a, sgn_b, neg_d;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [32:0] div_sh, div_diff;
  logic [31:0] hi_d, lo_d;
  logic [63:0] prod_s;
  logic [31:0] div_val, div_s, result_d;

  // Capture-time operand conditioning: magnitudes of signed operands and the final result sign.
  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    case (funct3)
      3'b001:         begin sgn_a = rs1_data[31]; sgn_b = rs2_data[31]; end
      3'b010:         sgn_a = rs1_data[31];
      3'b100, 3'b110: begin sgn_a = rs1_data[31]; sgn_b = rs2_data[31]; end
      default:        ;
    endcase
    mag_a = sgn_a ? (~rs1_data + 32'd1) : rs1_data;
    mag_b = sgn_b ? (~rs2_data + 32'd1) : rs2_data;
    // A remainder takes the dividend's sign. Every other result takes the XOR of both signs.
    neg_d = (funct3[2] && funct3[1]) ? sgn_a : (sgn_a ^ sgn_b);
  end

  // A multiply holds the 64-bit product in {hi,lo}. A divide keeps the remainder in hi and the quotient in lo.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : 33'd0);
    div_sh   = {hi_q, lo_q[31]};
    div_diff = div_sh - {1'b0, mcand_q};
    if (op_q[2]) begin
      if (!div_diff[32]) begin
        hi_d = div_diff[31:0];
        lo_d = {lo_q[30:0], 1'b1};
      end else begin
        hi_d = div_sh[31:0];
        lo_d = {lo_q[30:0], 1'b0};
      end
    end else begin
      hi_d = mul_sum[32:1];
      lo_d = {mul_sum[0], lo_q[31:1]};
    end
  end

  always_comb begin
    prod_s  = neg_q ? (~{hi_q, lo_q} + 64'd1) : {hi_q, lo_q};
    div_val = op_q[1] ? hi_q : lo_q;
    div_s   = neg_q ? (~div_val + 32'd1) : div_val;
    if (op_q[2]) begin
      // A remainder from a zero divisor is the dividend. That result needs no special case.
      result_d = (div0_q && !op_q[1]) ? 32'hFFFF_FFFF : div_s;
    end else begin
      result_d = (op_q == 3'b000) ? prod_s[31:0] : prod_s[63:32];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      op_q    <= 3'd0;
      rd_q    <= 5'd0;
      neg_q   <= 1'b0;
      div0_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      mcand_q <= 32'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_ena  <= 1'b0;
      wr_addr <= 5'd0;
      wr_data <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          done   <= 1'b0;
          wr_ena <= 1'b0;
          if (start) begin
            state_q <= CALC;
            cnt_q   <= 6'd0;
            op_q    <= funct3;
            rd_q    <= rd_addr;
            neg_q   <= neg_d;
            div0_q  <= (rs2_data == 32'd0);
            hi_q    <= 32'd0;
            lo_q    <= mag_a;
            mcand_q <= mag_b;
            busy    <= 1'b1;
          end
        end
        CALC: begin
          if (cnt_q == 6'd32) begin
            state_q <= DONE;
            done    <= 1'b1;
            wr_ena  <= (rd_q != 5'd0);
            wr_addr <= rd_q;
            wr_data <= result_d;
          end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 6'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          wr_ena  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit. Expected results are pushed when an op is issued.
// A negedge monitor pops an entry on each done pulse and checks its data, address, enable and latency.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1_data = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic [4:0]  rd_addr = 5'd0;
  logic        busy, done, wr_ena;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
    .busy(busy), .done(done), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        ena;
    int          cyc;
    string       name;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pulse", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          tests++;
          if (wr_data !== e.data || wr_addr !== e.addr || wr_ena !== e.ena || cyc != e.cyc) begin
            fails++;
            $display("FAIL %s: got data=0x%08h addr=%0d ena=%0b cyc=%0d, expected data=0x%08h addr=%0d ena=%0b cyc=%0d",
                     e.name, wr_data, wr_addr, wr_ena, cyc, e.data, e.addr, e.ena, e.cyc);
          end else begin
            $display("[TB] %s data=0x%08h addr=%0d ena=%0b cyc=%0d ok", e.name, wr_data, wr_addr, wr_ena, cyc);
          end
        end
      end else if (wr_ena) begin
        tests++; fails++;
        $display("FAIL stray_wr_ena: got wr_ena=1 without done at cycle %0d, expected 0", cyc);
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_data, input string name,
                       input bit push);
    @(negedge clk);
    funct3 = f; rs1_data = a; rs2_data = b; rd_addr = rd; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) sb.push_back('{rd, exp_data, (rd != 5'd0), cyc + 33, name});
    // Scramble the inputs so the result can only come from the captured operands.
    funct3 = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom; rd_addr = 5'($urandom);
    @(negedge clk);
    check({name, "_busy"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (sb.size() != 0 && n < 60);
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL timeout: got %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_idle();
    wait_done();
    @(negedge clk); #1;
    check("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy",    {31'd0, busy},   32'd0);
    check("rst_done",    {31'd0, done},   32'd0);
    check("rst_wr_ena",  {31'd0, wr_ena}, 32'd0);
    check("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    check("rst_wr_data", wr_data,         32'd0);
    rst = 1'b0;

    issue(3'b000, 32'd7,        32'hFFFF_FFFA, 5'd5,  32'hFFFF_FFD6, "mul_7_m6", 1);       wait_idle();
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, "mulhu_ff", 1);      wait_idle();
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000, "mulh_m1", 1);       wait_idle();
    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, "mulhsu_m1", 1);     wait_idle();
    issue(3'b000, 32'h1234_5678, 32'h0000_0010, 5'd9, 32'h2345_6780, "mul_shift", 1);     wait_idle();
    issue(3'b100, 32'hFFFF_FFF9, 32'd2,        5'd10, 32'hFFFF_FFFD, "div_m7_2", 1);      wait_idle();
    issue(3'b110, 32'hFFFF_FFF9, 32'd2,        5'd11, 32'hFFFF_FFFF, "rem_m7_2", 1);      wait_idle();
    issue(3'b101, 32'd100,      32'd0,         5'd12, 32'hFFFF_FFFF, "divu_by0", 1);      wait_idle();
    issue(3'b111, 32'd100,      32'd0,         5'd13, 32'd100,       "remu_by0", 1);      wait_idle();
    issue(3'b100, 32'hFFFF_FFF9, 32'd0,        5'd14, 32'hFFFF_FFFF, "div_m7_by0", 1);    wait_idle();
    issue(3'b110, 32'hFFFF_FFF9, 32'd0,        5'd15, 32'hFFFF_FFF9, "rem_m7_by0", 1);    wait_idle();
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, "div_ovf", 1);      wait_idle();
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000, "rem_ovf", 1);      wait_idle();
    issue(3'b111, 32'd1000,     32'd7,         5'd18, 32'd6,         "remu_1000_7", 1);   wait_idle();
    issue(3'b101, 32'd100,      32'd3,         5'd0,  32'd33,        "divu_rd0", 1);      wait_idle();

    // A second start while busy must be dropped and must not disturb the op in flight.
    issue(3'b101, 32'd1000, 32'd7, 5'd3, 32'd142, "divu_restart", 1);
    repeat (8) @(negedge clk);
    funct3 = 3'b000; rs1_data = 32'd5; rs2_data = 32'd5; rd_addr = 5'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);

    // A start during the DONE cycle must be dropped as well.
    issue(3'b011, 32'h0001_0000, 32'h0001_0000, 5'd4, 32'd1, "mulhu_done_start", 1);
    wait_done();
    funct3 = 3'b000; rs1_data = 32'd2; rs2_data = 32'd2; rd_addr = 5'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk); #1;
    check("start_in_done_ignored", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);

    // A reset during CALC aborts the op without a write.
    issue(3'b000, 32'd9, 32'd9, 5'd20, 32'd81, "mul_aborted", 0);
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy",   {31'd0, busy},   32'd0);
    check("abort_done",   {31'd0, done},   32'd0);
    check("abort_wr_ena", {31'd0, wr_ena}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(3'b000, 32'd3, 32'd4, 5'd21, 32'd12, "mul_after_rst", 1);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running, expected finish");
    $fatal(1, "timeout");
  end

endmodule
